// File: rtl/imem_boot_ctrl_if.sv
// Byte-stream link between the host loader and the imemory boot controller.
// The host side drives valid/data; the controller side answers with ready.
interface imem_boot_ctrl_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;

    modport master (output rx_valid, output rx_data, input rx_ready);
    modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/imem_boot_ctrl.sv
// Boot loader for the instruction memory: unpacks a counted little-endian byte stream into
// consecutive imemory words, stalls the CPU while loading, then hands the read port to fetch.
module imem_boot_ctrl #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_boot_ctrl_if.slave   link,
    input  logic              reload,
    input  logic [WIDTH-1:0]  cpu_pc,
    output logic [WIDTH-1:0]  cpu_instr,
    output logic              cpu_stall,
    output logic              cpu_misalign,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_DRAIN,
        S_RUN
    } state_t;

    // Counts are compared in 17 bits so a 16-bit header can never alias DEPTH.
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t      state;
    state_t      state_next;
    logic        ready;
    logic        accept;
    logic        last_word;
    logic        in_range;
    logic [15:0] n_words;
    logic [15:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] pack;
    logic        unused_pc_bits;

    assign ready     = (state == S_LEN0) || (state == S_LEN1) || (state == S_DATA);
    assign accept    = link.rx_valid && ready;
    assign last_word = ({1'b0, word_cnt} + 17'd1) == {1'b0, n_words};
    assign in_range  = {1'b0, word_cnt} < DEPTH_L;

    assign link.rx_ready = ready;
    assign cpu_stall     = (state != S_RUN);
    assign load_done     = (state == S_RUN);
    assign cpu_misalign  = (state == S_RUN) && (cpu_pc[1:0] != 2'b00);
    assign cpu_instr     = (state == S_RUN) ? mem_rdata : '0;
    assign mem_raddr     = cpu_pc[ADDR_W+1:2];

    // Fetch addresses above the imemory window are deliberately ignored.
    assign unused_pc_bits = ^cpu_pc[WIDTH-1:ADDR_W+2];

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LEN0;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            S_LEN0: begin
                if (accept) state_next = S_LEN1;
            end
            S_LEN1: begin
                if (accept) begin
                    state_next = ({link.rx_data, n_words[7:0]} == 16'd0) ? S_RUN : S_DATA;
                end
            end
            S_DATA: begin
                if (accept && (byte_cnt == 2'd3) && last_word) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                state_next = S_RUN;
            end
            S_RUN: begin
                if (reload) state_next = S_LEN0;
            end
            default: begin
                state_next = S_LEN0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_words      <= '0;
            word_cnt     <= '0;
            byte_cnt     <= '0;
            pack         <= '0;
            mem_we       <= 1'b0;
            mem_waddr    <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
            load_err     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (mem_we) words_loaded <= words_loaded + (ADDR_W+1)'(1);

            unique case (state)
                S_LEN0: begin
                    byte_cnt <= '0;
                    word_cnt <= '0;
                    if (accept) n_words[7:0] <= link.rx_data;
                end
                S_LEN1: begin
                    if (accept) begin
                        n_words[15:8] <= link.rx_data;
                        load_err      <= {1'b0, link.rx_data, n_words[7:0]} > DEPTH_L;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // Words past the end of imemory are consumed but never written.
                            if (in_range) begin
                                mem_we    <= 1'b1;
                                mem_waddr <= word_cnt[ADDR_W-1:0];
                                mem_wdata <= {link.rx_data, pack};
                            end
                            word_cnt <= word_cnt + 16'd1;
                        end else begin
                            pack <= {link.rx_data, pack[23:8]};
                        end
                    end
                end
                S_DRAIN: begin
                end
                S_RUN: begin
                    if (reload) begin
                        words_loaded <= '0;
                        load_err     <= 1'b0;
                        byte_cnt     <= '0;
                        word_cnt     <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
